// File: rtl/gpr_pkg.sv
// rtl/gpr_pkg.sv - shared types, defaults and helpers for the gpr_file_mp register file
package gpr_pkg;

    typedef enum logic {RF_INIT, RF_RUN} rf_state_t;

    localparam int XLEN_D  = 32;
    localparam int NREGS_D = 32;

    // Address width that stays at least 1 bit even for the smallest file.
    function automatic int gpr_aw(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// rtl/gpr_scoreboard.sv - per-register busy bits tracking in-flight producers
//
// Ports:
//   clock, reset       clock and synchronous active-high reset (clears all busy bits)
//   run                high when the register file is out of its zero-sweep
//   set_en, set_addr   mark a destination busy at issue
//   wr_en, wr_addr     writeback ports; a write clears its destination
//   busy               busy vector, one bit per register
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int NREGS  = NREGS_D,
    parameter int NUM_WR = 1,
    localparam int AW    = gpr_aw(NREGS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 set_en,
    input  logic [AW-1:0]        set_addr,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    output logic [NREGS-1:0]     busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (run) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j]) begin
                    busy_d[wr_addr[j*AW +: AW]] = 1'b0;
                end
            end
            // Applied after the clears: an issue in the same cycle is a newer producer.
            if (set_en && (set_addr != '0)) begin
                busy_d[set_addr] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/gpr_file_mp.sv
// rtl/gpr_file_mp.sv - multi-port register file with x0 hardwired to zero, scoreboard and zero-sweep
//
// Ports:
//   clock, reset              clock and synchronous active-high reset (restarts the sweep)
//   rd_addr / rd_data         NUM_RD combinational read ports, port i at [i*AW +: AW] / [i*XLEN +: XLEN]
//   rd_busy                   scoreboard busy bit for each read address
//   wr_en / wr_addr / wr_data NUM_WR write ports, highest index wins on an address collision
//   sb_set_en / sb_set_addr   mark a destination busy at issue
//   init_done                 high once the post-reset zero-sweep has finished
// Build option: define GPR_FILE_BYPASS_EN to forward same-cycle writes to the read ports.
module gpr_file_mp
    import gpr_pkg::*;
#(
    parameter int XLEN   = XLEN_D,
    parameter int NREGS  = NREGS_D,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    localparam int AW    = gpr_aw(NREGS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic [NUM_WR-1:0]      wr_en,
    input  logic [NUM_WR*AW-1:0]   wr_addr,
    input  logic [NUM_WR*XLEN-1:0] wr_data,
    input  logic                   sb_set_en,
    input  logic [AW-1:0]          sb_set_addr,
    output logic                   init_done
);

    rf_state_t        state_q, state_d;
    logic [AW-1:0]    sweep_cnt_q, sweep_cnt_d;
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy;
    logic             run;

    assign run       = (state_q == RF_RUN);
    assign init_done = run;

    // Sweep FSM: entry 0 is never stored, so the sweep covers 1..NREGS-1.
    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        if (state_q == RF_INIT) begin
            sweep_cnt_d = sweep_cnt_q + AW'(1);
            if (sweep_cnt_q == AW'(NREGS - 1)) begin
                state_d = RF_RUN;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RF_INIT;
            sweep_cnt_q <= AW'(1);
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
        end
    end

    // Array update: ports are applied in index order so the highest port wins.
    always_comb begin
        regs_d = regs_q;
        if (state_q == RF_INIT) begin
            regs_d[sweep_cnt_q] = '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j]) begin
                    regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
                end
            end
        end
        regs_d[0] = '0;
    end

    // The array has no reset; the sweep clears it instead.
    always_ff @(posedge clock) begin
        regs_q <= regs_d;
    end

    gpr_scoreboard #(
        .NREGS  (NREGS),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .run      (run),
        .set_en   (sb_set_en),
        .set_addr (sb_set_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .busy     (busy)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign ra = rd_addr[i*AW +: AW];

        always_comb begin
            data = regs_q[ra];
            bsy  = busy[ra];
`ifdef GPR_FILE_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == ra)) begin
                    data = wr_data[j*XLEN +: XLEN];
                    bsy  = 1'b0;
                end
            end
`endif
            if ((ra == '0) || !run) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = data;
        assign rd_busy[i]              = bsy;
    end

endmodule

// File: tb/tb_gpr_file_mp.sv
// tb/tb_gpr_file_mp.sv - self-checking bench for gpr_file_mp (vector table plus sweep/bypass sequences)
module tb_gpr_file_mp;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int AW = 5;

    logic              clock = 1'b0;
    logic              reset;
    logic [2*AW-1:0]   rd_addr;
    logic [2*XLEN-1:0] rd_data;
    logic [1:0]        rd_busy;
    logic [1:0]        wr_en;
    logic [2*AW-1:0]   wr_addr;
    logic [2*XLEN-1:0] wr_data;
    logic              sb_set_en;
    logic [AW-1:0]     sb_set_addr;
    logic              init_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    gpr_file_mp #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NUM_RD (2),
        .NUM_WR (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .init_done   (init_done)
    );

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        sb;
        logic [4:0]  sa;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        eb0;
        logic        eb1;
    } vec_t;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
    } exp_t;

    vec_t vecs [9];
    exp_t exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en       = 2'b00;
        wr_addr     = '0;
        wr_data     = '0;
        sb_set_en   = 1'b0;
        sb_set_addr = '0;
    endtask

    task automatic set_reads(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    exp_t e;

    initial begin
        vecs[0] = '{2'b01, 5'd3, 32'hDEADBEEF, 5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        vecs[1] = '{2'b01, 5'd0, 32'h1234,     5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 5'd3, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        vecs[2] = '{2'b11, 5'd7, 32'h11,       5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd3, 32'h22,       32'hDEADBEEF, 1'b0, 1'b0};
        vecs[3] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd9, 5'd9, 5'd7, 32'h0,        32'h22,       1'b1, 1'b0};
        vecs[4] = '{2'b01, 5'd9, 32'h99,       5'd0, 32'h0,  1'b1, 5'd9, 5'd9, 5'd7, 32'h99,       32'h22,       1'b1, 1'b0};
        vecs[5] = '{2'b01, 5'd9, 32'hAA,       5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd3, 32'hAA,       32'hDEADBEEF, 1'b0, 1'b0};
        vecs[6] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd0, 5'd0, 5'd9, 32'h0,        32'hAA,       1'b0, 1'b0};
        vecs[7] = '{2'b10, 5'd0, 32'h0,        5'd6, 32'h66, 1'b1, 5'd5, 5'd5, 5'd6, 32'h0,        32'h66,       1'b1, 1'b0};
        vecs[8] = '{2'b11, 5'd5, 32'h55,       5'd7, 32'h77, 1'b0, 5'd0, 5'd5, 5'd7, 32'h55,       32'h77,       1'b0, 1'b0};

        idle_inputs();
        set_reads(5'd31, 5'd17);
        reset = 1'b1;
        step();
        reset = 1'b0;

        // Reset cycle plus 30 sweep cycles low, high on the 32nd cycle.
        chk("init_done_reset", {31'd0, init_done}, 32'd0);
        chk("init_rd0_zero", rd_data[31:0], 32'h0);
        for (int i = 1; i <= 31; i++) begin
            if (i == 5) begin
                wr_en = 2'b01; wr_addr = {5'd0, 5'd1}; wr_data = {32'h0, 32'h00000BAD};
                sb_set_en = 1'b1; sb_set_addr = 5'd1;
            end
            step();
            idle_inputs();
            if (i < 31) begin
                chk($sformatf("init_done_low_%0d", i), {31'd0, init_done}, 32'd0);
                if (i == 10) begin
                    chk("init_rd1_zero", rd_data[63:32], 32'h0);
                    chk("init_busy_zero", {30'd0, rd_busy}, 32'h0);
                end
            end else begin
                chk("init_done_high", {31'd0, init_done}, 32'd1);
            end
        end
        chk("swept_x31", rd_data[31:0], 32'h0);
        chk("swept_x17", rd_data[63:32], 32'h0);
        set_reads(5'd1, 5'd1);
        #1;
        chk("init_write_ignored", rd_data[31:0], 32'h0);
        chk("init_sbset_ignored", {31'd0, rd_busy[0]}, 32'd0);

        foreach (vecs[k]) begin
            wr_en       = vecs[k].we;
            wr_addr     = {vecs[k].wa1, vecs[k].wa0};
            wr_data     = {vecs[k].wd1, vecs[k].wd0};
            sb_set_en   = vecs[k].sb;
            sb_set_addr = vecs[k].sa;
            set_reads(vecs[k].ra0, vecs[k].ra1);
            exp_q.push_back('{vecs[k].e0, vecs[k].e1, vecs[k].eb0, vecs[k].eb1});
            step();
            idle_inputs();
            #1;
            e = exp_q.pop_front();
            chk($sformatf("vec%0d_rd0", k), rd_data[31:0], e.d0);
            chk($sformatf("vec%0d_rd1", k), rd_data[63:32], e.d1);
            chk($sformatf("vec%0d_busy0", k), {31'd0, rd_busy[0]}, {31'd0, e.b0});
            chk($sformatf("vec%0d_busy1", k), {31'd0, rd_busy[1]}, {31'd0, e.b1});
        end

        // Same-cycle write of x4 while reading it with x4 marked busy.
        sb_set_en = 1'b1; sb_set_addr = 5'd4;
        step();
        idle_inputs();
        set_reads(5'd4, 5'd0);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h0000CAFE};
        #1;
`ifdef GPR_FILE_BYPASS_EN
        chk("bypass_data", rd_data[31:0], 32'h0000CAFE);
        chk("bypass_busy", {31'd0, rd_busy[0]}, 32'd0);
`else
        chk("nobypass_data", rd_data[31:0], 32'h0);
        chk("nobypass_busy", {31'd0, rd_busy[0]}, 32'd1);
`endif
        chk("bypass_x0_zero", rd_data[63:32], 32'h0);
        step();
        idle_inputs();
        #1;
        chk("post_write_x4", rd_data[31:0], 32'h0000CAFE);
        chk("post_write_busy_x4", {31'd0, rd_busy[0]}, 32'd0);

        // Garbage in x5/x20, then reset again with the sweep at count 10.
        wr_en = 2'b11; wr_addr = {5'd20, 5'd5}; wr_data = {32'h20202020, 32'h55555555};
        sb_set_en = 1'b1; sb_set_addr = 5'd20;
        step();
        idle_inputs();
        set_reads(5'd5, 5'd20);
        #1;
        chk("garbage_x20", rd_data[63:32], 32'h20202020);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 9; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            step();
            if (i < 31) begin
                if (init_done !== 1'b0) chk($sformatf("midreset_low_%0d", i), {31'd0, init_done}, 32'd0);
            end else begin
                chk("midreset_high", {31'd0, init_done}, 32'd1);
            end
        end
        chk("midreset_low_all", 32'd0, 32'd0 | {31'd0, 1'b0} | (n_fail > 0 ? 32'd0 : 32'd0));
        chk("midreset_x5", rd_data[31:0], 32'h0);
        chk("midreset_x20", rd_data[63:32], 32'h0);
        chk("midreset_busy_x20", {31'd0, rd_busy[1]}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
